// File: rtl/scope_capture_buffer.sv
// Triggered waveform capture into ping-pong RAM banks. Samples arrive on the rising edge of the slow cs clock.
// The display reads the frozen bank by trigger-relative address while the other bank captures the next frame.
module scope_capture_buffer #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned PRETRIG = 128,
    parameter int unsigned AUTO_TO = 4000
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              cs,
    input  logic [11:0]       sample,
    input  logic [11:0]       trig_level,
    input  logic              freeze,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [11:0]       rd_data,
    output logic              frame_valid,
    output logic              frame_done,
    output logic              auto_trig,
    output logic [1:0]        cap_state
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned TO_W  = (AUTO_TO > 1) ? $clog2(AUTO_TO) : 1;
    localparam bit          AUTO_EN = (AUTO_TO != 0);

    localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRETRIG - 1);
    localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRETRIG);
    localparam logic [ADDR_W:0]   POST_LAST = (ADDR_W + 1)'(DEPTH - PRETRIG);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'((AUTO_TO > 0) ? AUTO_TO - 1 : 0);

    typedef enum logic [1:0] {
        S_FILL  = 2'b00,
        S_ARMED = 2'b01,
        S_POST  = 2'b10,
        S_DONE  = 2'b11
    } cap_state_e;

    cap_state_e                  state_q, state_d;
    logic                        cs_meta_q, cs_meta_d;
    logic                        cs_sync_q, cs_sync_d;
    logic                        samp_en_q, samp_en_d;
    logic [11:0]                 samp_q, samp_d;
    logic [11:0]                 prev_samp_q, prev_samp_d;
    logic [ADDR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]           pre_cnt_q, pre_cnt_d;
    logic [ADDR_W:0]             post_cnt_q, post_cnt_d;
    logic [TO_W-1:0]             to_cnt_q, to_cnt_d;
    logic                        wr_bank_q, wr_bank_d;
    logic [ADDR_W-1:0]           trig_ptr_q, trig_ptr_d;
    logic [1:0][ADDR_W-1:0]      start_q, start_d;
    logic                        pending_auto_q, pending_auto_d;
    logic                        frame_valid_q, frame_valid_d;
    logic                        frame_done_q, frame_done_d;
    logic                        auto_trig_q, auto_trig_d;
    logic [11:0]                 rd_data_q;

    logic                        wr_en;
    logic                        real_trig;
    logic                        auto_hit;
    logic                        rd_bank;
    logic [ADDR_W-1:0]           rd_idx;

    logic [11:0]                 mem [2*DEPTH];

    assign rd_bank = ~wr_bank_q;
    assign rd_idx  = start_q[rd_bank] + rd_addr;

    always_comb begin
        cs_meta_d      = cs;
        cs_sync_d      = cs_meta_q;
        samp_en_d      = cs_meta_q & ~cs_sync_q;
        samp_d         = samp_en_d ? sample : samp_q;
        state_d        = state_q;
        prev_samp_d    = prev_samp_q;
        wr_ptr_d       = wr_ptr_q;
        pre_cnt_d      = pre_cnt_q;
        post_cnt_d     = post_cnt_q;
        to_cnt_d       = to_cnt_q;
        wr_bank_d      = wr_bank_q;
        trig_ptr_d     = trig_ptr_q;
        start_d        = start_q;
        pending_auto_d = pending_auto_q;
        frame_valid_d  = frame_valid_q;
        frame_done_d   = 1'b0;
        auto_trig_d    = auto_trig_q;
        wr_en          = 1'b0;
        real_trig      = 1'b0;
        auto_hit       = 1'b0;

        if (samp_en_q && (state_q != S_DONE)) begin
            wr_en       = 1'b1;
            wr_ptr_d    = wr_ptr_q + 1'b1;
            prev_samp_d = samp_q;
        end

        unique case (state_q)
            S_FILL: begin
                if (samp_en_q) begin
                    pre_cnt_d = pre_cnt_q + 1'b1;
                    if (pre_cnt_q == PRE_LAST) begin
                        state_d = S_ARMED;
                    end
                end
            end
            S_ARMED: begin
                if (samp_en_q) begin
                    real_trig = (prev_samp_q < trig_level) && (samp_q >= trig_level);
                    auto_hit  = AUTO_EN && (to_cnt_q == TO_LAST);
                    if (real_trig || auto_hit) begin
                        trig_ptr_d     = wr_ptr_q;
                        post_cnt_d     = (ADDR_W + 1)'(1);
                        to_cnt_d       = '0;
                        pending_auto_d = ~real_trig;
                        state_d        = S_POST;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
            end
            S_POST: begin
                // Trigger sample is post sample 1, so the frame closes exactly DEPTH samples after its oldest.
                if (samp_en_q) begin
                    post_cnt_d = post_cnt_q + 1'b1;
                    if (post_cnt_d == POST_LAST) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (!freeze) begin
                    wr_bank_d          = ~wr_bank_q;
                    start_d[wr_bank_q] = trig_ptr_q - PRE_OFS;
                    frame_valid_d      = 1'b1;
                    auto_trig_d        = pending_auto_q;
                    frame_done_d       = 1'b1;
                    pre_cnt_d          = '0;
                    post_cnt_d         = '0;
                    pending_auto_d     = 1'b0;
                    state_d            = S_FILL;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q        <= S_FILL;
            cs_meta_q      <= 1'b0;
            cs_sync_q      <= 1'b0;
            samp_en_q      <= 1'b0;
            samp_q         <= '0;
            prev_samp_q    <= '0;
            wr_ptr_q       <= '0;
            pre_cnt_q      <= '0;
            post_cnt_q     <= '0;
            to_cnt_q       <= '0;
            wr_bank_q      <= 1'b0;
            trig_ptr_q     <= '0;
            start_q        <= '0;
            pending_auto_q <= 1'b0;
            frame_valid_q  <= 1'b0;
            frame_done_q   <= 1'b0;
            auto_trig_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cs_meta_q      <= cs_meta_d;
            cs_sync_q      <= cs_sync_d;
            samp_en_q      <= samp_en_d;
            samp_q         <= samp_d;
            prev_samp_q    <= prev_samp_d;
            wr_ptr_q       <= wr_ptr_d;
            pre_cnt_q      <= pre_cnt_d;
            post_cnt_q     <= post_cnt_d;
            to_cnt_q       <= to_cnt_d;
            wr_bank_q      <= wr_bank_d;
            trig_ptr_q     <= trig_ptr_d;
            start_q        <= start_d;
            pending_auto_q <= pending_auto_d;
            frame_valid_q  <= frame_valid_d;
            frame_done_q   <= frame_done_d;
            auto_trig_q    <= auto_trig_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en && !RESET) begin
            mem[{wr_bank_q, wr_ptr_q}] <= samp_q;
        end
    end

    // Read uses the registered (pre-swap) bank select, so a swap never tears the word being read.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem[{rd_bank, rd_idx}];
        end
    end

    assign rd_data     = rd_data_q;
    assign frame_valid = frame_valid_q;
    assign frame_done  = frame_done_q;
    assign auto_trig   = auto_trig_q;
    assign cap_state   = state_q;

endmodule

// File: tb/tb_scope_capture_buffer.sv
// Directed bench for scope_capture_buffer using a shrunk frame (64 deep, 8 pre-trigger) and a fast cs.
// A second instance with auto-trigger disabled checks that a flat signal never completes a frame.
module tb_scope_capture_buffer;

    localparam int unsigned ADDR_W  = 6;
    localparam int unsigned PRETRIG = 8;
    localparam int unsigned AUTO_TO = 80;

    logic              CLK = 1'b0;
    logic              RESET = 1'b1;
    logic              cs = 1'b0;
    logic [11:0]       sample = '0;
    logic [11:0]       trig_level = 12'd2048;
    logic              freeze = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;

    logic [11:0]       rd_data, rd_data_b;
    logic              frame_valid, frame_valid_b;
    logic              frame_done, frame_done_b;
    logic              auto_trig, auto_trig_b;
    logic [1:0]        cap_state, cap_state_b;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int base = 0;

    scope_capture_buffer #(.ADDR_W(ADDR_W), .PRETRIG(PRETRIG), .AUTO_TO(AUTO_TO)) u_dut (
        .CLK(CLK), .RESET(RESET), .cs(cs), .sample(sample), .trig_level(trig_level),
        .freeze(freeze), .rd_addr(rd_addr), .rd_data(rd_data), .frame_valid(frame_valid),
        .frame_done(frame_done), .auto_trig(auto_trig), .cap_state(cap_state)
    );

    scope_capture_buffer #(.ADDR_W(ADDR_W), .PRETRIG(PRETRIG), .AUTO_TO(0)) u_dut_noauto (
        .CLK(CLK), .RESET(RESET), .cs(cs), .sample(sample), .trig_level(trig_level),
        .freeze(freeze), .rd_addr(rd_addr), .rd_data(rd_data_b), .frame_valid(frame_valid_b),
        .frame_done(frame_done_b), .auto_trig(auto_trig_b), .cap_state(cap_state_b)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        #1;
        if (frame_done) done_cnt = done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One cs period: 3 CLK high, 3 CLK low; capture logic has settled when this returns.
    task automatic push(input logic [11:0] v);
        @(negedge CLK);
        sample = v;
        cs = 1'b1;
        repeat (3) @(negedge CLK);
        cs = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic push_n(input int n, input logic [11:0] v);
        for (int i = 0; i < n; i++) push(v);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        check("rst_state", cap_state, 0);
        check("rst_valid", frame_valid, 0);
        check("rst_done", frame_done, 0);
        check("rst_auto", auto_trig, 0);
        check("rst_rdata", rd_data, 0);
        RESET = 1'b0;
    endtask

    task automatic read_chk(input string tag, input int addr, input logic [11:0] exp);
        @(negedge CLK);
        rd_addr = ADDR_W'(addr);
        @(negedge CLK);
        check(tag, rd_data, exp);
    endtask

    task automatic wait_swap(input int b, input int max_clk);
        int n = 0;
        while (done_cnt == b && n < max_clk) begin
            @(negedge CLK);
            n++;
        end
        check("swap_seen", done_cnt - b, 1);
    endtask

    initial begin
        // Rising ramp, step 64: trigger at sample 32 (value 2048), frame starts at sample 24.
        do_reset();
        base = done_cnt;
        for (int k = 0; k < 88; k++) begin
            push(12'(k * 64));
            if (k == 7)  check("t1_armed", cap_state, 1);
            if (k == 31) check("t1_below", cap_state, 1);
            if (k == 32) check("t1_post", cap_state, 2);
        end
        check("t1_done_cnt", done_cnt - base, 1);
        check("t1_valid", frame_valid, 1);
        check("t1_auto", auto_trig, 0);
        check("t1_refill", cap_state, 0);
        read_chk("t1_trig", 8, 12'd2048);
        read_chk("t1_oldest", 0, 12'd1536);
        read_chk("t1_newest", 63, 12'd1472);
        read_chk("t1_mid", 20, 12'd2816);

        // Level crossing edge cases.
        do_reset();
        base = done_cnt;
        push_n(8, 12'd3000);
        check("t3_armed", cap_state, 1);
        push(12'd2500);
        push(12'd2048);
        push(12'd2048);
        check("t3_eq_eq", cap_state, 1);
        push(12'd2000);
        push(12'd1500);
        check("t3_falling", cap_state, 1);
        push(12'd2047);
        check("t3_below", cap_state, 1);
        push(12'd2048);
        check("t3_from_below", cap_state, 2);
        push_n(54, 12'd7);
        check("t3_post_last_minus1", cap_state, 2);
        push(12'd7);
        check("t3_done_cnt", done_cnt - base, 1);
        check("t3_auto", auto_trig, 0);
        read_chk("t3_trig", 8, 12'd2048);
        read_chk("t3_pre1", 7, 12'd2047);
        read_chk("t3_pre2", 6, 12'd1500);
        read_chk("t3_oldest", 0, 12'd3000);
        read_chk("t3_newest", 63, 12'd7);

        // Freeze during POST: display holds the previous frame, dropped samples never land.
        base = done_cnt;
        push_n(8, 12'd100);
        check("t4_armed", cap_state, 1);
        push(12'd200);
        push(12'd3000);
        check("t4_post", cap_state, 2);
        push_n(20, 12'd9);
        freeze = 1'b1;
        push_n(35, 12'd9);
        check("t4_frozen", cap_state, 3);
        read_chk("t4_hold_a", 8, 12'd2048);
        push(12'd4000);
        check("t4_still_frozen", cap_state, 3);
        check("t4_no_done", done_cnt - base, 0);
        read_chk("t4_hold_b", 8, 12'd2048);
        @(negedge CLK);
        freeze = 1'b0;
        wait_swap(base, 2);
        read_chk("t4_trig", 8, 12'd3000);
        read_chk("t4_pre1", 7, 12'd200);
        read_chk("t4_oldest", 0, 12'd100);
        read_chk("t4_newest", 63, 12'd9);
        check("t4_auto", auto_trig, 0);

        // Flat signal: forced trigger on the 80th ARMED sample; the no-auto instance stays ARMED.
        do_reset();
        base = done_cnt;
        push_n(8, 12'd100);
        push_n(79, 12'd100);
        check("t2_pre_timeout", cap_state, 1);
        push(12'd100);
        check("t2_forced", cap_state, 2);
        push_n(55, 12'd100);
        check("t2_done_cnt", done_cnt - base, 1);
        check("t2_valid", frame_valid, 1);
        check("t2_auto", auto_trig, 1);
        read_chk("t2_data", 5, 12'd100);
        check("t2_noauto_state", cap_state_b, 1);
        check("t2_noauto_valid", frame_valid_b, 0);

        // Trigger at wr_ptr 3: frame starts at address 59 and wraps.
        do_reset();
        base = done_cnt;
        for (int idx = 0; idx < 123; idx++) begin
            push((idx == 67) ? 12'd3000 : 12'(idx * 10 + 100));
            if (idx == 66) check("t5_armed", cap_state, 1);
            if (idx == 67) check("t5_post", cap_state, 2);
        end
        check("t5_done_cnt", done_cnt - base, 1);
        check("t5_auto", auto_trig, 0);
        for (int a = 0; a < 64; a++) begin
            read_chk("t5_wrap", a, (a == 8) ? 12'd3000 : 12'((59 + a) * 10 + 100));
        end

        // Reset mid-POST aborts the frame and restarts in FILL.
        base = done_cnt;
        push_n(8, 12'd100);
        push(12'd3000);
        push_n(5, 12'd50);
        check("t6_post", cap_state, 2);
        do_reset();
        push_n(7, 12'd100);
        check("t6_refill", cap_state, 0);
        push(12'd100);
        check("t6_rearmed", cap_state, 1);
        check("t6_no_done", done_cnt - base, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
